// File: rtl/abr_masked_pipe_sched_pkg.sv
// Shared types and default parameters for the masked pipeline scheduler.
package abr_params_pkg;

  localparam int unsigned DEF_WIDTH     = 46;
  localparam int unsigned DEF_LATENCY   = 5;
  localparam int unsigned DEF_MAX_OUTST = 3;
  localparam int unsigned NUM_SHARES    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } sched_state_e;

  // Requester identifier: two requesters share the pipeline.
  typedef logic req_id_t;

endpackage

// File: rtl/abr_masked_pipe_sched_if.sv
// Requester, datapath and response signals of the masked pipeline scheduler.
interface abr_masked_pipe_sched_if
  import abr_params_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  // Masked operand: index [s] selects share s, each WIDTH bits.
  typedef logic [NUM_SHARES-1:0][WIDTH-1:0] shares_t;

  logic [1:0] req_i;
  shares_t    req0_shares_i;
  shares_t    req1_shares_i;
  logic [1:0] gnt_o;
  logic       pipe_valid_o;
  shares_t    pipe_shares_o;
  shares_t    pipe_shares_i;
  logic [1:0] rsp_valid_o;
  shares_t    rsp_shares_o;

  // Requesters and the datapath drive the scheduler.
  modport master (
    output req_i, req0_shares_i, req1_shares_i, pipe_shares_i,
    input  gnt_o, pipe_valid_o, pipe_shares_o, rsp_valid_o, rsp_shares_o
  );

  // The scheduler itself.
  modport slave (
    input  req_i, req0_shares_i, req1_shares_i, pipe_shares_i,
    output gnt_o, pipe_valid_o, pipe_shares_o, rsp_valid_o, rsp_shares_o
  );

endinterface

// File: rtl/abr_masked_pipe_sched_tag_pipe.sv
// LATENCY-deep {valid, id} shift register tracking the owner of each
// operation in flight through the shared datapath.
module abr_sched_tag_pipe
  import abr_params_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    zeroize,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id,
  output logic    empty_next
);

  logic [LATENCY-1:0]          vld_q;
  req_id_t [LATENCY-1:0]       id_q;

  // Shift one stage per cycle; zeroize drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else if (zeroize) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], in_valid};
      id_q  <= {id_q[LATENCY-2:0], in_id};
    end
  end

  // Last stage owns the datapath output; the pipe is empty next cycle when
  // nothing sits ahead of the last stage.
  always_comb begin
    out_valid  = vld_q[LATENCY-1];
    out_id     = id_q[LATENCY-1];
    empty_next = ~|vld_q[LATENCY-2:0];
  end

endmodule

// File: rtl/abr_masked_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency masked datapath between
// two requesters, with per-requester outstanding limits and zeroize flush.
module abr_masked_pipe_sched
  import abr_params_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    zeroize,
  abr_masked_pipe_sched_if.slave  bus,
  output logic                    busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned FW = $clog2(LATENCY);

  typedef logic [OW-1:0]                      outst_t;
  typedef logic [NUM_SHARES-1:0][WIDTH-1:0]   shares_t;

  sched_state_e      state_q, state_n;
  logic              last_q;
  outst_t [1:0]      outst_q;
  logic [FW-1:0]     fcnt_q;
  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [1:0]        rsp_vld;
  req_id_t           win;
  logic              any_gnt;
  shares_t           issue_sh;
  shares_t           rsp_sh;
  logic              tp_valid;
  req_id_t           tp_id;
  logic              tp_empty_next;

  // Eligibility, round-robin pick and issue mux. Reset also gates grants so
  // outputs are quiet while rst_n is low.
  always_comb begin
    elig = '0;
    win  = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      elig[k] = rst_n && bus.req_i[k] && (outst_q[k] < outst_t'(MAX_OUTST)) &&
                (state_q != ST_FLUSH) && !zeroize;
    end
    case (elig)
      2'b11:   win = ~last_q;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
    any_gnt  = |elig;
    gnt      = any_gnt ? (win ? 2'b10 : 2'b01) : 2'b00;
    issue_sh = '0;
    if (gnt[0])      issue_sh = bus.req0_shares_i;
    else if (gnt[1]) issue_sh = bus.req1_shares_i;
    bus.gnt_o         = gnt;
    bus.pipe_valid_o  = any_gnt;
    bus.pipe_shares_o = issue_sh;
  end

  abr_sched_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .zeroize    (zeroize),
    .in_valid   (any_gnt),
    .in_id      (win),
    .out_valid  (tp_valid),
    .out_id     (tp_id),
    .empty_next (tp_empty_next)
  );

  // Route the datapath output to its owner; zeroize suppresses it.
  always_comb begin
    rsp_vld = '0;
    if (tp_valid && !zeroize) rsp_vld[tp_id] = 1'b1;
    rsp_sh           = (|rsp_vld) ? bus.pipe_shares_i : '0;
    bus.rsp_valid_o  = rsp_vld;
    bus.rsp_shares_o = rsp_sh;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (zeroize)      state_n = ST_FLUSH;
        else if (any_gnt) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (zeroize)                        state_n = ST_FLUSH;
        else if (!any_gnt && tp_empty_next) state_n = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!zeroize && (fcnt_q == FW'(LATENCY - 1))) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_o = (state_q != ST_IDLE);
  end

  // Flush counter: restarts on every zeroize cycle, counts while flushing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   fcnt_q <= '0;
    else if (zeroize)             fcnt_q <= '0;
    else if (state_q == ST_FLUSH) fcnt_q <= fcnt_q + FW'(1);
    else                          fcnt_q <= '0;
  end

  // Last-grant pointer; its idle value of 1 hands the first tie to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b1;
    else if (zeroize) last_q <= 1'b1;
    else if (any_gnt) last_q <= win;
  end

  // Outstanding counters: +1 per grant, -1 per response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else if (zeroize) begin
      outst_q <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        case ({gnt[k], rsp_vld[k]})
          2'b10:   outst_q[k] <= outst_q[k] + outst_t'(1);
          2'b01:   outst_q[k] <= outst_q[k] - outst_t'(1);
          default: outst_q[k] <= outst_q[k];
        endcase
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_outst_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(gnt[k] && !rsp_vld[k] && (outst_q[k] == outst_t'(MAX_OUTST))));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_vld[k] && !gnt[k] && (outst_q[k] == '0)));
  end

endmodule

// File: doc/abr_masked_pipe_sched.md
# abr_masked_pipe_sched

Round-robin scheduler that shares one fixed-latency masked (2-share) datapath pipeline, such as the masked-shares delay line or a masked gadget chain, between two requesters. It grants at most one issue per cycle, muxes the winner's shares into the pipeline, and tracks an in-flight tag per stage so each result returns to its owner exactly LATENCY cycles later. It also enforces a per-requester outstanding limit and quiesces the pipeline for LATENCY cycles on zeroize.

## Interface
- WIDTH, 46: number of masked bit positions (each position is 2 shares).
- LATENCY, 5: datapath latency in cycles, ≥2; must equal the controlled pipeline's depth.
- MAX_OUTST, 3: maximum in-flight operations per requester, 1..LATENCY.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- zeroize  in  1  synchronous clear plus flush request.
- req_i  in  2  per-requester issue request, level.
- req0_shares_i  in  [1:0]×WIDTH  requester 0 operand shares.
- req1_shares_i  in  [1:0]×WIDTH  requester 1 operand shares.
- gnt_o  out  2  one-hot or zero; issue accepted this cycle.
- pipe_valid_o  out  1  datapath input is a real operation.
- pipe_shares_o  out  [1:0]×WIDTH  shares into the datapath.
- pipe_shares_i  in  [1:0]×WIDTH  datapath output shares.
- rsp_valid_o  out  2  result for requester k is on rsp_shares_o.
- rsp_shares_o  out  [1:0]×WIDTH  result shares.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: no operations in flight.
  - ACTIVE: at least one operation in flight or being issued.
  - FLUSH: zeroize quiesce.
- Transitions:
  - IDLE→ACTIVE on any grant.
  - ACTIVE→IDLE when the tag pipe is empty after this cycle and there is no grant.
  - Any state→FLUSH on zeroize.
  - FLUSH→IDLE when the flush counter reaches LATENCY-1 and zeroize is low.
- Eligibility: req_i[k] && outst[k] < MAX_OUTST && state ≠ FLUSH && !zeroize.
- Arbitration:
  - If one requester is eligible, it wins.
  - If both are eligible, the one not granted most recently wins.
  - The last-grant pointer updates only on a grant; its reset value is 1, so requester 0 wins the first tie.
- Issue (combinational):
  - pipe_valid_o = |gnt_o.
  - pipe_shares_o = winner's shares, or all-zero when there is no grant. Never forward an ungranted requester's shares.
- Tag pipe:
  - LATENCY stages of {valid, id}.
  - Stage 0 loads {|gnt_o, winner id} each cycle.
  - Stage LATENCY-1 drives rsp_valid_o[id] = valid.
- Response: rsp_shares_o = pipe_shares_i when any rsp_valid_o is set, else all-zero.
- Outstanding counters:
  - outst[k] is $clog2(MAX_OUTST+1) bits wide.
  - +1 on gnt_o[k], -1 on rsp_valid_o[k]; a simultaneous grant and response leaves it unchanged.
  - Never wraps; overflow and underflow are assertion failures.
- Zeroize:
  - Clears the tag pipe, counters and pointer, and forces gnt_o, pipe_valid_o and rsp_valid_o to 0 in the same cycle.
  - The flush counter restarts from 0 on every zeroize cycle.
- Reset values: every output 0, state IDLE, all counters 0.

## Timing
- A grant is combinational in the request cycle t; the result appears on rsp_valid_o in cycle t+LATENCY.
- Throughput is one issue per cycle, limited per requester by MAX_OUTST.
- A response freeing a slot in cycle t makes that requester eligible in t+1, not t.
- rsp_valid_o has no ready signal; requesters must accept in the valid cycle.
- FLUSH lasts LATENCY cycles after the last zeroize cycle; busy_o stays high throughout.
- If reset asserts mid-operation, all state is cleared asynchronously and in-flight results are dropped.

## Structure
- Shared package abr_params_pkg:
  - state enum (IDLE, ACTIVE, FLUSH);
  - requester id type (1 bit);
  - masked-share array typedef parameterized by WIDTH convention.
- One natural sub-module: abr_sched_tag_pipe, the LATENCY-deep {valid, id} shift register with zeroize.
- Arbiter, counters and FSM stay in the top module.

## Test plan
- Single op: req_i=01 for one cycle with shares {a,b} → gnt_o=01 at t, rsp_valid_o=01 at t+5 carrying the pipeline output, busy_o falls at t+6.
- Contention: req_i=11 held for 6 cycles → grants alternate 01,10,01,10,…; responses alternate identically from t+5.
- Limit: req_i=01 held, MAX_OUTST=3 → grants at t..t+2, none at t+3..t+5, next grant at t+6 (slot freed by the response at t+5).
- Zeroize with 3 in flight → zero outputs the same cycle, no rsp_valid_o afterward, gnt_o blocked for 5 cycles, then IDLE.
- Reset mid-flight → all outputs 0 immediately; after release a new request completes normally with the counters correct.
